// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types, imported by the register file,
// ALU and decoder so operand and address widths stay consistent.
package cpu_pkg;

  localparam int W        = 8;
  localparam int D        = 4;
  localparam int FLAG_REG = 12;

  typedef logic [D-1:0] reg_addr_t;
  typedef logic [W-1:0] data_t;

endpackage : cpu_pkg

// File: rtl/reg_file_if.sv
// Register file bus: two ALU operand read ports, general and flag write ports,
// and a debug read port. The master drives addresses and write data.
interface reg_file_if #(
  parameter int W = cpu_pkg::W,
  parameter int D = cpu_pkg::D
);

  logic [D-1:0] RaddrA;
  logic [D-1:0] RaddrB;
  logic [W-1:0] DataOutA;
  logic [W-1:0] DataOutB;
  logic         WriteEn;
  logic [D-1:0] Waddr;
  logic [W-1:0] DataIn;
  logic         FlagWriteEn;
  logic         FlagIn;
  logic [D-1:0] DbgAddr;
  logic [W-1:0] DbgData;

  modport master (
    output RaddrA, RaddrB, WriteEn, Waddr, DataIn, FlagWriteEn, FlagIn, DbgAddr,
    input  DataOutA, DataOutB, DbgData
  );

  modport slave (
    input  RaddrA, RaddrB, WriteEn, Waddr, DataIn, FlagWriteEn, FlagIn, DbgAddr,
    output DataOutA, DataOutB, DbgData
  );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// 2**D x W architectural register file: three combinational read ports, one
// general write port and a flag write port that targets FLAG_REG.
module reg_file #(
  parameter int W        = cpu_pkg::W,
  parameter int D        = cpu_pkg::D,
  parameter int FLAG_REG = cpu_pkg::FLAG_REG,
  parameter int ZERO_R0  = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  reg_file_if.slave  bus
);

  localparam int           DEPTH     = 2**D;
  localparam logic [D-1:0] FLAG_ADDR = D'(FLAG_REG);
  localparam bit           R0_FIXED  = (ZERO_R0 != 0);

  logic [W-1:0] regs [DEPTH];

  logic gen_wr;
  logic flag_wr;

  // The flag port owns FLAG_REG in a collision; a hardwired r0 swallows
  // writes from either port.
  always_comb begin
    gen_wr  = bus.WriteEn
              && !(R0_FIXED && bus.Waddr == '0)
              && !(bus.FlagWriteEn && bus.Waddr == FLAG_ADDR);
    flag_wr = bus.FlagWriteEn && !(R0_FIXED && FLAG_ADDR == '0);
  end

  // NOTE: the whole array is reset here, unlike a RAM macro; the ALU may read
  // any register before it is written, and it must see 0 rather than X.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      regs <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments, so reads in this cycle see old state.
      if (gen_wr)  regs[bus.Waddr] <= bus.DataIn;
      if (flag_wr) regs[FLAG_ADDR] <= {{(W-1){1'b0}}, bus.FlagIn};
    end
  end

  // No write bypass: the ALU loops combinationally back to DataIn.
  function automatic logic [W-1:0] rd(input logic [D-1:0] addr);
    if (R0_FIXED && addr == '0) return '0;
    return regs[addr];
  endfunction

  always_comb begin
    bus.DataOutA = rd(bus.RaddrA);
    bus.DataOutB = rd(bus.RaddrB);
    bus.DbgData  = rd(bus.DbgAddr);
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one instance with ordinary r0, one with
// hardwired r0, both sharing clock and reset.
module tb_reg_file;
  import cpu_pkg::*;

  logic Clk;
  logic Reset;

  reg_file_if ba ();
  reg_file_if bz ();

  reg_file #(.ZERO_R0(0)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ba.slave));
  reg_file #(.ZERO_R0(1)) dut_z (.Clk(Clk), .Reset(Reset), .bus(bz.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic      we;
    reg_addr_t wa;
    data_t     din;
    logic      fwe;
    logic      fin;
    reg_addr_t ra;
    reg_addr_t rb;
    reg_addr_t dbg;
    data_t     ea;
    data_t     eb;
    data_t     ed;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input data_t act, input data_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic we, input reg_addr_t wa, input data_t din,
                         input logic fwe, input logic fin);
    ba.WriteEn     = we;
    ba.Waddr       = wa;
    ba.DataIn      = din;
    ba.FlagWriteEn = fwe;
    ba.FlagIn      = fin;
  endtask

  task automatic drive_z(input logic we, input reg_addr_t wa, input data_t din,
                         input logic fwe, input logic fin);
    bz.WriteEn     = we;
    bz.Waddr       = wa;
    bz.DataIn      = din;
    bz.FlagWriteEn = fwe;
    bz.FlagIn      = fin;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Table state on entry: r5 = 3C, all others 0.
    //          we  wa  din    fwe fin  ra  rb  dbg  ea     eb     ed
    vt[0] = '{1'b1, 12, 8'hFF, 1'b0, 1'b0, 12,  5, 12, 8'hFF, 8'h3C, 8'hFF};
    vt[1] = '{1'b0,  0, 8'h00, 1'b1, 1'b0, 12, 12, 12, 8'h00, 8'h00, 8'h00};
    vt[2] = '{1'b0,  0, 8'h00, 1'b1, 1'b1, 12,  5,  0, 8'h01, 8'h3C, 8'h00};
    vt[3] = '{1'b1, 12, 8'h77, 1'b1, 1'b1, 12, 12, 12, 8'h01, 8'h01, 8'h01};
    vt[4] = '{1'b1,  7, 8'h77, 1'b1, 1'b1,  7, 12,  7, 8'h77, 8'h01, 8'h77};
    vt[5] = '{1'b1,  0, 8'hAB, 1'b0, 1'b0,  0,  7,  0, 8'hAB, 8'h77, 8'hAB};
    vt[6] = '{1'b0,  7, 8'hEE, 1'b0, 1'b0,  7,  0, 12, 8'h77, 8'hAB, 8'h01};
    vt[7] = '{1'b1,  3, 8'hA5, 1'b0, 1'b0,  3, 12,  3, 8'hA5, 8'h01, 8'hA5};
    vt[8] = '{1'b1, 15, 8'h80, 1'b1, 1'b1, 15, 12, 15, 8'h80, 8'h01, 8'h80};
    vt[9] = '{1'b1, 12, 8'h55, 1'b1, 1'b0, 12, 15,  3, 8'h00, 8'h80, 8'hA5};

    Reset = 1'b0;
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    drive_z(1'b0, '0, '0, 1'b0, 1'b0);
    ba.RaddrA = 4'd3;  ba.RaddrB = 4'd12; ba.DbgAddr = 4'd15;
    bz.RaddrA = '0;    bz.RaddrB = '0;    bz.DbgAddr = '0;

    // Reset state
    #12;
    check("reset_a",   ba.DataOutA, 8'h00);
    check("reset_b",   ba.DataOutB, 8'h00);
    check("reset_dbg", ba.DbgData,  8'h00);

    // Write-to-read latency: old value during the write cycle, new after.
    @(negedge Clk);
    Reset = 1'b1;
    drive_a(1'b1, 4'd5, 8'h3C, 1'b0, 1'b0);
    ba.RaddrA = 4'd5; ba.DbgAddr = 4'd5;
    #1;
    check("lat_old_a", ba.DataOutA, 8'h00);
    tick();
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    check("lat_new_a",   ba.DataOutA, 8'h3C);
    check("lat_new_dbg", ba.DbgData,  8'h3C);

    // Table-driven write/flag/collision vectors.
    for (int i = 0; i < 10; i++) begin
      drive_a(vt[i].we, vt[i].wa, vt[i].din, vt[i].fwe, vt[i].fin);
      ba.RaddrA  = vt[i].ra;
      ba.RaddrB  = vt[i].rb;
      ba.DbgAddr = vt[i].dbg;
      tick();
      drive_a(1'b0, '0, '0, 1'b0, 1'b0);
      check($sformatf("vec%0d_a", i),   ba.DataOutA, vt[i].ea);
      check($sformatf("vec%0d_b", i),   ba.DataOutB, vt[i].eb);
      check($sformatf("vec%0d_dbg", i), ba.DbgData,  vt[i].ed);
    end

    // Fill r0..r15 with 10+i, then sweep all read-address pairs.
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, reg_addr_t'(i), data_t'(8'h10 + i), 1'b0, 1'b0);
      tick();
    end
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ba.RaddrA  = reg_addr_t'(a);
        ba.RaddrB  = reg_addr_t'(b);
        ba.DbgAddr = reg_addr_t'(a + b);
        #1;
        check($sformatf("sweep_a_%0d", a),   ba.DataOutA, data_t'(8'h10 + a));
        check($sformatf("sweep_b_%0d", b),   ba.DataOutB, data_t'(8'h10 + b));
        check($sformatf("sweep_dbg_%0d", (a + b) % 16), ba.DbgData,
              data_t'(8'h10 + ((a + b) % 16)));
      end
    end

    // Hold: 20 idle cycles with write data/address wiggling but no enables.
    for (int c = 0; c < 20; c++) begin
      drive_a(1'b0, reg_addr_t'($urandom_range(15)), data_t'($urandom_range(255)),
              1'b0, 1'($urandom_range(1)));
      tick();
    end
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ba.DbgAddr = reg_addr_t'(i);
      #1;
      check($sformatf("hold_r%0d", i), ba.DbgData, data_t'(8'h10 + i));
    end

    // Hardwired r0 instance.
    drive_z(1'b1, 4'd0, 8'hFF, 1'b0, 1'b0);
    tick();
    drive_z(1'b0, '0, '0, 1'b0, 1'b0);
    check("z_r0_a",   bz.DataOutA, 8'h00);
    check("z_r0_b",   bz.DataOutB, 8'h00);
    check("z_r0_dbg", bz.DbgData,  8'h00);
    drive_z(1'b1, 4'd1, 8'hFF, 1'b1, 1'b1);
    bz.RaddrA = 4'd1; bz.RaddrB = 4'd12; bz.DbgAddr = 4'd0;
    tick();
    drive_z(1'b0, '0, '0, 1'b0, 1'b0);
    check("z_r1_a",   bz.DataOutA, 8'hFF);
    check("z_flag_b", bz.DataOutB, 8'h01);
    check("z_r0_dbg2", bz.DbgData, 8'h00);

    // Asynchronous reset mid-cycle, writes ignored during reset.
    drive_a(1'b1, 4'd3, 8'hA5, 1'b0, 1'b0);
    ba.RaddrA = 4'd3; ba.RaddrB = 4'd12; ba.DbgAddr = 4'd3;
    tick();
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    check("pre_rst_a", ba.DataOutA, 8'hA5);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_async_a",   ba.DataOutA, 8'h00);
    check("rst_async_dbg", ba.DbgData,  8'h00);
    check("rst_async_z1",  bz.DataOutA, 8'h00);
    drive_a(1'b1, 4'd3, 8'h5A, 1'b1, 1'b1);
    tick();
    tick();
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    check("rst_wr_a", ba.DataOutA, 8'h00);
    check("rst_wr_b", ba.DataOutB, 8'h00);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("rel_r3", ba.DataOutA, 8'h00);
    drive_a(1'b1, 4'd3, 8'hC3, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    check("first_wr_a", ba.DataOutA, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
- 16-entry x 8-bit architectural register file directly upstream of the ALU.
- Two combinational read ports drive the ALU's InputA/InputB.
- A clocked write port accepts the ALU result (Out); a dedicated flag write port captures the ALU's Zero/SLT bit into flag register r12.
- A third read-only debug port lets the testbench inspect state without disturbing the datapath.

Parameters:
- W, 8, data width in bits; matches ALU operand width.
- D, 4, address width; depth = 2**D registers.
- FLAG_REG, 12, index of the register written by the flag port.
- ZERO_R0, 0, when 1, r0 reads as 0 and ignores all writes.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- RaddrA  input  D  read address for operand A.
- RaddrB  input  D  read address for operand B.
- DataOutA  output  W  contents of RaddrA; feeds ALU InputA.
- DataOutB  output  W  contents of RaddrB; feeds ALU InputB.
- WriteEn  input  1  general write enable.
- Waddr  input  D  general write address.
- DataIn  input  W  general write data (ALU Out or load data).
- FlagWriteEn  input  1  flag write enable.
- FlagIn  input  1  flag bit (ALU Zero).
- DbgAddr  input  D  debug read address.
- DbgData  output  W  contents of DbgAddr.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low.
- Reset (Reset==0): all 2**D registers clear to 0 immediately, independent of Clk, and stay 0 while asserted.
  - Consequently DataOutA, DataOutB and DbgData read 0 during reset.
  - Writes presented while Reset==0 are discarded.
  - On deassertion, the first write takes effect at the first rising Clk edge with Reset==1.
- Reads: purely combinational from current register state; zero-cycle latency.
  - No write-to-read bypass. A read of the address being written in the same cycle returns the OLD value; the new value is visible after the edge.
  - Rationale: the ALU is combinational back to DataIn, so a bypass would create a combinational loop.
- General write: on rising Clk with WriteEn==1, reg[Waddr] <= DataIn. Latency is 1 cycle.
- Flag write: on rising Clk with FlagWriteEn==1, reg[FLAG_REG] <= {(W-1)'b0, FlagIn}, i.e. upper bits are zeroed.
- Both ports in one cycle:
  - Different addresses: both writes occur.
  - Both target FLAG_REG: the flag port wins and the general write to FLAG_REG is dropped.
- ZERO_R0==1:
  - Writes to r0 from either port are ignored.
  - All read ports return 0 for address 0.
  - If FLAG_REG==0 with ZERO_R0==1, flag writes are discarded.
- ZERO_R0==0: r0 is an ordinary register.
- Registers not written in a cycle hold their value.
- No X propagation: all storage has a defined reset value, and unknown addresses are not possible because all 2**D entries exist.
- Concurrency: the three read ports are fully independent and may all address the same register simultaneously.

Decomposition:
- Shared package (cpu_pkg) holds:
  - constants W=8 and D=4;
  - FLAG_REG=12;
  - a typedef for register address (logic [D-1:0]);
  - a typedef for data word (logic [W-1:0]).
- ALU and decoder import the same package so operand and address widths stay consistent.
- No sub-module is needed. The storage array, write-arbitration logic and three read muxes live in reg_file itself.
- The read mux is replicated three times via a local function, not a separate module.

Test Plan:
- Reset clears state: write 8'hA5 to r3, then assert Reset (low) mid-cycle -> DataOutA (RaddrA=3) goes to 8'h00 before the next Clk edge; a write attempted during reset leaves r3 = 8'h00 after release.
- Write/read latency: WriteEn=1, Waddr=5, DataIn=8'h3C, RaddrA=5 -> DataOutA shows the old value (8'h00) in the write cycle and 8'h3C after the edge; DbgAddr=5 also shows 8'h3C.
- Flag port: FlagWriteEn=1, FlagIn=1 -> r12 = 8'h01. Preload r12=8'hFF via the general port, then flag-write FlagIn=0 -> r12 = 8'h00.
- Write collision: same cycle WriteEn=1, Waddr=12, DataIn=8'h77, FlagWriteEn=1, FlagIn=1 -> r12 = 8'h01. Repeat with Waddr=7 -> r7 = 8'h77 and r12 = 8'h01.
- Dual read and hold: fill r0..r15 with 8'h10+i, then sweep RaddrA/RaddrB/DbgAddr over all pairs with WriteEn=0 -> every output matches its expected value; no register changes across 20 idle cycles.
- ZERO_R0=1 build: write 8'hFF to r0 -> DataOutA, DataOutB and DbgData at address 0 all read 8'h00. Write 8'hFF to r1 -> r1 reads 8'hFF.
